// File: rtl/sr_latch_seq_pkg.sv
// sr_latch_seq_pkg: shared definitions for the gated SR latch sequencer.
//   state_e  - sequencer states (IDLE=0, SETUP=1, PULSE=2, HOLD=3)
//   OP_SET   - op value requesting a latch set
//   OP_RESET - op value requesting a latch reset
package sr_latch_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

endpackage

// File: rtl/sr_latch_seq_ctrl_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter (purely combinational).
// Ports:
//   req   [1:0] in  - request vector, bit n = requester n
//   ptr         in  - priority pointer, 0 favours requester 0, 1 favours requester 1
//   grant [1:0] out - one-hot grant (all zero when no request)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/sr_latch_seq_ctrl.sv
// sr_latch_seq_ctrl: drives a bank of gated SR latches with a fixed
// SETUP / PULSE / HOLD write sequence on behalf of two requesters.
// Optional feature macro: SR_LATCH_SEQ_READBACK_EN (checks lat_q[idx]
// against the written value in HOLD and flags err on mismatch).
// Parameters:
//   N_LATCH      - number of latches driven
//   PULSE_CYCLES - gate-enable width in clk cycles (1..15)
// Ports:
//   clk, rst            in  - clock (rising edge), synchronous active-high reset
//   req0/req1           in  - write request from requester 0/1
//   op0/op1             in  - 1 = set, 0 = reset
//   idx0/idx1           in  - target latch index
//   gnt0/gnt1           out - one-cycle grant pulse (during SETUP)
//   lat_c               out - per-latch gate enable, active-high
//   lat_s_n/lat_r_n     out - shared set/reset, active-low
//   lat_q               in  - latch Q readback
//   busy, done, err     out - status; done/err pulse in HOLD
module sr_latch_seq_ctrl
  import sr_latch_seq_pkg::*;
#(
  parameter  int unsigned N_LATCH      = 4,
  parameter  int unsigned PULSE_CYCLES = 2,
  localparam int unsigned IDX_W        = (N_LATCH > 1) ? $clog2(N_LATCH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic               op0,
  input  logic               op1,
  input  logic [IDX_W-1:0]   idx0,
  input  logic [IDX_W-1:0]   idx1,
  output logic               gnt0,
  output logic               gnt1,
  output logic [N_LATCH-1:0] lat_c,
  output logic               lat_s_n,
  output logic               lat_r_n,
  input  logic [N_LATCH-1:0] lat_q,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [IDX_W:0] N_LIM   = (IDX_W+1)'(N_LATCH);
  localparam logic [3:0]     CNT_LD  = 4'(PULSE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               ptr_q, ptr_d;
  logic               op_q, op_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic [N_LATCH-1:0] lat_c_q, lat_c_d;
  logic               lat_s_n_q, lat_s_n_d;
  logic               lat_r_n_q, lat_r_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [1:0]         grant;
  logic               win_op;
  logic [IDX_W-1:0]   win_idx;
  logic               idx_ok;
  logic [N_LATCH-1:0] lat_c_sel;
  logic               rb_bad;

  rr_arb2 u_arb (
    .req   ({req1, req0}),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign win_op  = grant[1] ? op1  : op0;
  assign win_idx = grant[1] ? idx1 : idx0;
  assign idx_ok  = ({1'b0, idx_q} < N_LIM);

  // Out-of-range indices leave every gate closed.
  always_comb begin
    lat_c_sel = '0;
    if (idx_ok) begin
      lat_c_sel[idx_q] = 1'b1;
    end
  end

`ifdef SR_LATCH_SEQ_READBACK_EN
  // Sampled on the edge leaving PULSE so the result lands in HOLD
  // together with done; the gate has been open for the whole pulse.
  assign rb_bad = idx_ok && (lat_q[idx_q] != op_q);
`else
  logic unused_lat_q;
  assign unused_lat_q = ^lat_q;
  assign rb_bad       = 1'b0;
`endif

  // Outputs are registered, so each branch computes the values that
  // will be visible during the state being entered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    op_d      = op_q;
    idx_d     = idx_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    lat_c_d   = '0;
    lat_s_n_d = lat_s_n_q;
    lat_r_n_d = lat_r_n_q;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d    = 1'b0;
        lat_s_n_d = 1'b1;
        lat_r_n_d = 1'b1;
        if (grant != 2'b00) begin
          state_d   = SETUP;
          op_d      = win_op;
          idx_d     = win_idx;
          ptr_d     = grant[0];
          gnt0_d    = grant[0];
          gnt1_d    = grant[1];
          busy_d    = 1'b1;
          lat_s_n_d = (win_op != OP_SET);
          lat_r_n_d = (win_op != OP_RESET);
        end
      end
      SETUP: begin
        state_d = PULSE;
        cnt_d   = CNT_LD;
        lat_c_d = lat_c_sel;
      end
      PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          done_d  = 1'b1;
          err_d   = !idx_ok || rb_bad;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          lat_c_d = lat_c_sel;
        end
      end
      HOLD: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        lat_s_n_d = 1'b1;
        lat_r_n_d = 1'b1;
      end
      default: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        lat_s_n_d = 1'b1;
        lat_r_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= 1'b0;
      op_q      <= 1'b0;
      idx_q     <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      lat_c_q   <= '0;
      lat_s_n_q <= 1'b1;
      lat_r_n_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      lat_c_q   <= lat_c_d;
      lat_s_n_q <= lat_s_n_d;
      lat_r_n_q <= lat_r_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign lat_c   = lat_c_q;
  assign lat_s_n = lat_s_n_q;
  assign lat_r_n = lat_r_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_sr_latch_seq_ctrl.sv
// tb_sr_latch_seq_ctrl: self-checking bench for sr_latch_seq_ctrl with
// N_LATCH=3 (so index 3 is out of range) and PULSE_CYCLES=2. Directed
// scenarios plus a randomized run against a timeline model in which each
// accepted request occupies a fixed run of cycles after acceptance.
`timescale 1ns/1ps
module tb_sr_latch_seq_ctrl;

  localparam int unsigned N  = 3;
  localparam int unsigned P  = 2;
  localparam int unsigned IW = 2;
  localparam int unsigned VW = N + 7;

  logic          clk = 1'b0;
  logic          rst, req0, req1, op0, op1;
  logic [IW-1:0] idx0, idx1;
  logic          gnt0, gnt1, lat_s_n, lat_r_n, busy, done, err;
  logic [N-1:0]  lat_c, lat_q, q_mem, stuck_mask, stuck_val;
  logic          mon_en = 1'b0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  sr_latch_seq_ctrl #(
    .N_LATCH      (N),
    .PULSE_CYCLES (P)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .op0     (op0),
    .op1     (op1),
    .idx0    (idx0),
    .idx1    (idx1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .lat_c   (lat_c),
    .lat_s_n (lat_s_n),
    .lat_r_n (lat_r_n),
    .lat_q   (lat_q),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  // Behavioural latch bank; stuck_mask forces selected Q bits.
  assign lat_q = (q_mem & ~stuck_mask) | (stuck_val & stuck_mask);

  always @(negedge clk) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (lat_c[i] === 1'b1) begin
        if (lat_s_n === 1'b0)      q_mem[i] = 1'b1;
        else if (lat_r_n === 1'b0) q_mem[i] = 1'b0;
      end
    end
  end

  // Per-cycle invariants: S/R never both active, at most one gate open.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (((lat_s_n | lat_r_n) !== 1'b1) || ($countones(lat_c) > 1)) begin
        errors++;
        $display("FAIL invariant: got s_n=%b r_n=%b lat_c=%b, required s_n|r_n=1 and popcount(lat_c)<=1",
                 lat_s_n, lat_r_n, lat_c);
      end
    end
  end

  logic [VW-1:0] obs;
  assign obs = {gnt0, gnt1, busy, done, err, lat_s_n, lat_r_n, lat_c};

  function automatic logic [VW-1:0] vec(input logic g0, input logic g1, input logic b,
                                        input logic d, input logic e, input logic sn,
                                        input logic rn, input logic [N-1:0] c);
    return {g0, g1, b, d, e, sn, rn, c};
  endfunction

  logic [VW-1:0] idle_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1; op0 = 1'b1; idx0 = 2'd1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (obs !== idle_v) begin
        errors++; $display("FAIL reset_idle: got %b required %b", obs, idle_v);
      end
    end
    mon_en = 1'b1;
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== vec(1, 0, 1, 0, 0, 0, 1, '0)) begin
      errors++; $display("FAIL reset_release_capture: got %b required %b", obs, vec(1, 0, 1, 0, 0, 0, 1, '0));
    end
    req0 = 1'b0;
    repeat (P + 2) tick();
    checks++;
    if (obs !== idle_v) begin
      errors++; $display("FAIL reset_drain: got %b required %b", obs, idle_v);
    end
  endtask

  task automatic test_single(input logic op, input int unsigned idx);
    logic [N-1:0] c;
    c = '0; c[idx] = 1'b1;
    req0 = 1'b1; op0 = op; idx0 = IW'(idx);
    tick();
    checks++;
    if (obs !== vec(1, 0, 1, 0, 0, !op, op, '0)) begin
      errors++; $display("FAIL single_setup: got %b required %b", obs, vec(1, 0, 1, 0, 0, !op, op, '0));
    end
    req0 = 1'b0;
    for (int unsigned p = 0; p < P; p++) begin
      tick();
      checks++;
      if (obs !== vec(0, 0, 1, 0, 0, !op, op, c)) begin
        errors++; $display("FAIL single_pulse: got %b required %b", obs, vec(0, 0, 1, 0, 0, !op, op, c));
      end
    end
    tick();
    checks++;
    if (obs !== vec(0, 0, 1, 1, 0, !op, op, '0)) begin
      errors++; $display("FAIL single_hold: got %b required %b", obs, vec(0, 0, 1, 1, 0, !op, op, '0));
    end
    tick();
    checks++;
    if (obs !== idle_v) begin
      errors++; $display("FAIL single_idle: got %b required %b", obs, idle_v);
    end
  endtask

  task automatic test_contention();
    do_reset();
    req0 = 1'b1; op0 = 1'b1; idx0 = 2'd0;
    req1 = 1'b1; op1 = 1'b0; idx1 = 2'd1;
    tick();
    checks++;
    if (obs !== vec(1, 0, 1, 0, 0, 0, 1, '0)) begin
      errors++; $display("FAIL contention_first: got %b required %b", obs, vec(1, 0, 1, 0, 0, 0, 1, '0));
    end
    req0 = 1'b0;
    repeat (P + 2) tick();
    checks++;
    if (obs !== idle_v) begin
      errors++; $display("FAIL contention_gap: got %b required %b", obs, idle_v);
    end
    tick();
    checks++;
    if (obs !== vec(0, 1, 1, 0, 0, 1, 0, '0)) begin
      errors++; $display("FAIL contention_second: got %b required %b", obs, vec(0, 1, 1, 0, 0, 1, 0, '0));
    end
    req0 = 1'b1; req1 = 1'b1;
    repeat (P + 3) tick();
    checks++;
    if (obs !== vec(1, 0, 1, 0, 0, 0, 1, '0)) begin
      errors++; $display("FAIL contention_third: got %b required %b", obs, vec(1, 0, 1, 0, 0, 0, 1, '0));
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (P + 2) tick();
  endtask

  task automatic test_back_to_back();
    int n;
    req0 = 1'b1; req1 = 1'b0; op0 = 1'b1; idx0 = 2'd2;
    n = 0;
    do begin tick(); n++; end while (gnt0 !== 1'b1 && n < 20);
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++; $display("FAIL b2b_first_grant: got no gnt0 in %0d cycles, required gnt0", n);
    end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin tick(); n++; end while (gnt0 !== 1'b1 && n < 20);
      checks++;
      if (n != int'(P + 3)) begin
        errors++; $display("FAIL b2b_spacing: got %0d cycles required %0d", n, P + 3);
      end
    end
    req0 = 1'b0;
    repeat (P + 2) tick();
  endtask

  task automatic test_reset_mid_pulse();
    req0 = 1'b1; req1 = 1'b0; op0 = 1'b1; idx0 = 2'd0;
    tick();
    req0 = 1'b0;
    tick();
    checks++;
    if (obs !== vec(0, 0, 1, 0, 0, 0, 1, 3'b001)) begin
      errors++; $display("FAIL midpulse_pre: got %b required %b", obs, vec(0, 0, 1, 0, 0, 0, 1, 3'b001));
    end
    rst = 1'b1;
    tick();
    checks++;
    if (obs !== idle_v) begin
      errors++; $display("FAIL midpulse_reset: got %b required %b", obs, idle_v);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (obs !== idle_v) begin
        errors++; $display("FAIL midpulse_no_done: got %b required %b", obs, idle_v);
      end
    end
    // Pointer was left favouring requester 1; reset must restore requester 0.
    req0 = 1'b1; req1 = 1'b1; op1 = 1'b0;
    tick();
    checks++;
    if (obs !== vec(1, 0, 1, 0, 0, 0, 1, '0)) begin
      errors++; $display("FAIL midpulse_ptr_reset: got %b required %b", obs, vec(1, 0, 1, 0, 0, 0, 1, '0));
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (P + 2) tick();
  endtask

  task automatic test_bad_index();
    req0 = 1'b1; op0 = 1'b1; idx0 = 2'd3;
    tick();
    checks++;
    if (obs !== vec(1, 0, 1, 0, 0, 0, 1, '0)) begin
      errors++; $display("FAIL badidx_setup: got %b required %b", obs, vec(1, 0, 1, 0, 0, 0, 1, '0));
    end
    req0 = 1'b0;
    for (int unsigned p = 0; p < P; p++) begin
      tick();
      checks++;
      if (obs !== vec(0, 0, 1, 0, 0, 0, 1, '0)) begin
        errors++; $display("FAIL badidx_pulse: got %b required %b", obs, vec(0, 0, 1, 0, 0, 0, 1, '0));
      end
    end
    tick();
    checks++;
    if (obs !== vec(0, 0, 1, 1, 1, 0, 1, '0)) begin
      errors++; $display("FAIL badidx_hold: got %b required %b", obs, vec(0, 0, 1, 1, 1, 0, 1, '0));
    end
    tick();
    checks++;
    if (obs !== idle_v) begin
      errors++; $display("FAIL badidx_idle: got %b required %b", obs, idle_v);
    end
  endtask

  task automatic test_readback();
    logic exp_err;
    for (int v = 0; v < 2; v++) begin
      stuck_mask = 3'b010;
      stuck_val  = (v == 0) ? 3'b000 : 3'b010;
`ifdef SR_LATCH_SEQ_READBACK_EN
      exp_err = (v == 0);
`else
      exp_err = 1'b0;
`endif
      req0 = 1'b1; op0 = 1'b1; idx0 = 2'd1;
      tick();
      req0 = 1'b0;
      repeat (P + 1) tick();
      checks++;
      if (obs !== vec(0, 0, 1, 1, exp_err, 0, 1, '0)) begin
        errors++; $display("FAIL readback_hold: got %b required %b", obs, vec(0, 0, 1, 1, exp_err, 0, 1, '0));
      end
      tick();
    end
    stuck_mask = '0;
    stuck_val  = '0;
  endtask

  task automatic test_random();
    int unsigned  pos, widx;
    bit           mptr, w, wop, h0, h1;
    logic [N-1:0] ec;
    logic [VW-1:0] exp_v;
    do_reset();
    pos = 0; widx = 0; mptr = 1'b0; w = 1'b0; wop = 1'b0; h0 = 1'b0; h1 = 1'b0;
    for (int it = 0; it < 400; it++) begin
      if (!h0 && $urandom_range(0, 2) == 0) begin
        h0 = 1'b1; op0 = 1'($urandom_range(0, 1)); idx0 = IW'($urandom_range(0, 3));
      end
      if (!h1 && $urandom_range(0, 2) == 0) begin
        h1 = 1'b1; op1 = 1'($urandom_range(0, 1)); idx1 = IW'($urandom_range(0, 3));
      end
      req0 = h0; req1 = h1;
      rst  = ($urandom_range(0, 39) == 0);
      tick();
      // Each accepted request occupies cycles 1 (grant), 2..P+1 (gate),
      // P+2 (done) after the accepting edge; 0 means idle.
      if (rst) begin
        pos = 0; mptr = 1'b0;
      end else if (pos == 0) begin
        if (h0 || h1) begin
          w    = (h0 && h1) ? mptr : h1;
          mptr = !w;
          wop  = w ? op1 : op0;
          widx = w ? int'(idx1) : int'(idx0);
          pos  = 1;
        end
      end else if (pos == P + 2) begin
        pos = 0;
      end else begin
        pos++;
      end
      ec = '0;
      if (pos >= 2 && pos <= P + 1 && widx < N) ec[widx] = 1'b1;
      exp_v = vec(pos == 1 && !w, pos == 1 && w, pos != 0, pos == P + 2,
                  pos == P + 2 && widx >= N,
                  (pos == 0) ? 1'b1 : !wop, (pos == 0) ? 1'b1 : wop, ec);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL random[%0d]: got %b required %b", it, obs, exp_v);
      end
      if (pos == 1) begin
        if (w) h1 = 1'b0; else h0 = 1'b0;
      end
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (P + 3) tick();
  endtask

  initial begin
    idle_v = vec(0, 0, 0, 0, 0, 1, 1, '0);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
    idx0 = '0; idx1 = '0; q_mem = '0; stuck_mask = '0; stuck_val = '0;
    test_reset();
    test_single(1'b1, 2);
    test_single(1'b0, 1);
    test_contention();
    test_back_to_back();
    test_reset_mid_pulse();
    test_bad_index();
    test_readback();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion within time limit, required $finish");
    $fatal(1);
  end

endmodule
